cdb_arbiter: RTL

- Shares the single result-broadcast bus between the two result producers: ALU reservation station and load/store buffer.
- Each source writes into its own small FIFO. One entry per cycle is granted onto the bus: round-robin when both FIFOs hold data.
- The bus drives the reorder buffer's ready/rob_id/value write port and the RS/LSB operand snoop.
- The bus is also flushed by the reorder buffer's mispredict `clear`.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_wb.sv | 78 +++++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared configuration for the common data bus (CDB) arbiter.
// Contents:
//   ROB_SIZE_WIDTH, DATA_WIDTH, FIFO_DEPTH : codebase-wide sizing
//   cdb_src_e                              : result source identifiers
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 3;
    localparam int DATA_WIDTH     = 32;
    localparam int FIFO_DEPTH     = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_wb.sv
// wb_fifo: small synchronous write-back FIFO that buffers one producer's
// results until they win the CDB.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, pop     enqueue din / dequeue head (caller guarantees !full / !empty)
//   flush         empty the FIFO; overrides push and pop
//   din           entry to enqueue
//   head          oldest entry (undefined content when empty)
//   empty, full   occupancy flags
module wb_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // push and pop together leave the count unchanged
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single result-broadcast bus between the ALU
// reservation station and the load/store buffer. Each source feeds its own
// wb_fifo; one head per cycle is broadcast, round-robin on ties.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   rdy                              global enable, low freezes all state
//   clear                            mispredict flush from the ROB
//   alu_valid/rob_id/value, alu_ready  ALU result handshake
//   lsb_valid/rob_id/value, lsb_ready  LSB result handshake
//   cdb_valid/rob_id/value           broadcast to ROB and operand snoop
//   cdb_src                          0 = ALU, 1 = LSB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = cdb_arbiter_pkg::ROB_SIZE_WIDTH,
    parameter int DATA_WIDTH     = cdb_arbiter_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH     = cdb_arbiter_pkg::FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic                      alu_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
    input  logic [DATA_WIDTH-1:0]     alu_value,
    output logic                      alu_ready,
    input  logic                      lsb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [DATA_WIDTH-1:0]     lsb_value,
    output logic                      lsb_ready,
    output logic                      cdb_valid,
    output logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
    output logic [DATA_WIDTH-1:0]     cdb_value,
    output logic                      cdb_src
);

    localparam int EW = ROB_SIZE_WIDTH + DATA_WIDTH;

    logic          alu_empty, alu_full, lsb_empty, lsb_full;
    logic [EW-1:0] alu_head, lsb_head, gnt_head;
    logic          alu_push, lsb_push, alu_pop, lsb_pop, flush;
    cdb_src_e      gnt_src;
    cdb_src_e      last_grant_q, last_grant_d;

    // Ready looks at occupancy only, so a pop in the same cycle gives no credit.
    assign alu_ready = !alu_full;
    assign lsb_ready = !lsb_full;

    always_comb begin
        gnt_src = SRC_ALU;
        if (!alu_empty && !lsb_empty) begin
            gnt_src = (last_grant_q == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end else if (!lsb_empty) begin
            gnt_src = SRC_LSB;
        end
        gnt_head = (gnt_src == SRC_LSB) ? lsb_head : alu_head;

        // A clearing cycle must not broadcast a result of a squashed path.
        cdb_valid  = rdy && !clear && (!alu_empty || !lsb_empty);
        cdb_rob_id = '0;
        cdb_value  = '0;
        cdb_src    = 1'b0;
        if (cdb_valid) begin
            {cdb_rob_id, cdb_value} = gnt_head;
            cdb_src                 = gnt_src;
        end

        flush    = rdy && clear;
        alu_push = alu_valid && alu_ready && rdy && !clear;
        lsb_push = lsb_valid && lsb_ready && rdy && !clear;
        alu_pop  = cdb_valid && (gnt_src == SRC_ALU);
        lsb_pop  = cdb_valid && (gnt_src == SRC_LSB);

        last_grant_d = cdb_valid ? gnt_src : last_grant_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SRC_LSB;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .flush (flush),
        .din   ({alu_rob_id, alu_value}),
        .head  (alu_head),
        .empty (alu_empty),
        .full  (alu_full)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .flush (flush),
        .din   ({lsb_rob_id, lsb_value}),
        .head  (lsb_head),
        .empty (lsb_empty),
        .full  (lsb_full)
    );

endmodule
